// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round helper functions for sha256_chain_core.
package sha256_pkg;

  typedef logic [31:0] word_t;
  // Element 0 sits in the top 32 bits, so a hstate_t maps directly onto the hash_out layout.
  typedef logic [0:7][31:0] hstate_t;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} fsm_e;

  localparam hstate_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// One combinational SHA-256 round: working variables a..h plus W[t], K[t] -> next a..h.
module sha256_round_comb
  import sha256_pkg::*;
(
  input  hstate_t s_in,
  input  word_t   w,
  input  word_t   k,
  output hstate_t s_out
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1    = s_in[7] + bsig1(s_in[4]) + ch(s_in[4], s_in[5], s_in[6]) + k + w;
    t2    = bsig0(s_in[0]) + maj(s_in[0], s_in[1], s_in[2]);
    s_out = {t1 + t2, s_in[0], s_in[1], s_in[2], s_in[3] + t1, s_in[4], s_in[5], s_in[6]};
  end

endmodule

// File: rtl/sha256_chain_core.sv
// Iterative SHA-256 compression core, UNROLL rounds per clock, chaining value kept internally.
// Optional SHA256_MIDSTATE_IN_EN adds midstate_in/midstate_ld to load an external chaining value.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
// in_ready is high only in IDLE, and out_valid/hash_out hold steady until out_ready is seen.
module sha256_chain_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_data,
  input  logic         first_block,
`ifdef SHA256_MIDSTATE_IN_EN
  input  logic [255:0] midstate_in,
  input  logic         midstate_ld,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] hash_out,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_chain_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] CNT_STEP = 6'(UNROLL);
  localparam logic [5:0] CNT_LAST = 6'(64 - UNROLL);

  fsm_e       state, state_nx;
  word_t      win [0:15];
  word_t      ext [0:15+UNROLL];
  hstate_t    h_reg, base, work, load_val, sum;
  hstate_t    chain [0:UNROLL];
  logic [5:0] cnt;

  // Window always holds W[t..t+15]; extending it by UNROLL words yields the next window.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
  end

  assign chain[0] = work;
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    sha256_round_comb u_round (
      .s_in  (chain[j]),
      .w     (ext[j]),
      .k     (K[cnt + 6'(j)]),
      .s_out (chain[j+1])
    );
  end

  always_comb begin
    load_val = first_block ? IV : h_reg;
`ifdef SHA256_MIDSTATE_IN_EN
    if (midstate_ld) load_val = midstate_in;
`endif
    for (int i = 0; i < 8; i++) sum[i] = base[i] + work[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid)                state_nx = S_ROUND;
      S_ROUND: if (cnt == CNT_LAST)         state_nx = S_FINAL;
      S_FINAL:                              state_nx = S_OUT;
      S_OUT:   if (out_valid && out_ready)  state_nx = S_IDLE;
      default:                              state_nx = S_IDLE;
    endcase
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      work      <= IV;
      base      <= IV;
      h_reg     <= IV;
      hash_out  <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          for (int i = 0; i < 16; i++) win[i] <= block_data[511-32*i -: 32];
          work <= load_val;
          base <= load_val;
          cnt  <= '0;
        end
        S_ROUND: begin
          work <= chain[UNROLL];
          for (int i = 0; i < 16; i++) win[i] <= ext[i+UNROLL];
          cnt  <= cnt + CNT_STEP;
        end
        S_FINAL: begin
          h_reg    <= sum;
          hash_out <= sum;
        end
        S_OUT: begin
          // out_valid rises on the first OUT cycle, drops on the handshake edge.
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_chain_core.sv
// Directed bench for sha256_chain_core: NIST vectors, chaining, backpressure, reset abort, midstate.
module tb_sha256_chain_core;

  parameter int UNROLL = 1;
  localparam int LAT = 64 / UNROLL + 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block_data;
  logic         first_block;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] hash_out;
  logic         busy;
  logic [255:0] midstate_in;
  logic         midstate_ld;

  sha256_chain_core #(.UNROLL(UNROLL)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .block_data  (block_data),
    .first_block (first_block),
`ifdef SHA256_MIDSTATE_IN_EN
    .midstate_in (midstate_in),
    .midstate_ld (midstate_ld),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .hash_out    (hash_out),
    .busy        (busy)
  );

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] H_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] H_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] H_MID   = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] H_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic [255:0] exp_q [$];
  time          acc_q [$];
  int           checks;
  int           errors;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver: waits for IDLE, presents one block for one accept edge.
  task automatic send(input logic [511:0] blk, input logic first, input logic ld,
                      input logic [255:0] mid, input logic expect_out, input logic [255:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_ready", 256'(in_ready), 256'd1);
      return;
    end
    block_data  = blk;
    first_block = first;
    midstate_ld = ld;
    midstate_in = mid;
    in_valid    = 1'b1;
    if (expect_out) exp_q.push_back(exp);
    @(posedge clk);
    if (expect_out) acc_q.push_back($time);
    @(negedge clk);
    in_valid    = 1'b0;
    midstate_ld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  256'(in_ready),  256'd1);
    chk({tag, "_out_valid"}, 256'(out_valid), 256'd0);
    chk({tag, "_busy"},      256'(busy),      256'd0);
    chk({tag, "_hash_out"},  hash_out,        256'd0);
  endtask

  // Monitor / scoreboard: samples 1 time unit after the falling edge.
  initial begin
    logic prev_v;
    time  t_acc;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_v && acc_q.size() != 0) begin
            t_acc = acc_q.pop_front();
            chk("latency", 256'((($time - 6) - t_acc) / 10), 256'(LAT));
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=%h required=no_output", hash_out);
          end else begin
            chk("hash", hash_out, exp_q[0]);
            chk("in_ready_low", 256'(in_ready), 256'd0);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_v = out_valid;
      end
    end
  end

  // Directed stimulus
  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    block_data  = '0;
    first_block = 1'b0;
    midstate_in = '0;
    midstate_ld = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    send(BLK_ABC, 1'b1, 1'b0, '0, 1'b1, H_ABC);
    wait_drain();
    send(BLK_EMPTY, 1'b1, 1'b0, '0, 1'b1, H_EMPTY);
    wait_drain();
    send(BLK_TWO1, 1'b1, 1'b0, '0, 1'b1, H_MID);
    send(BLK_TWO2, 1'b0, 1'b0, '0, 1'b1, H_TWO);
    wait_drain();

    // Backpressure with ignored in_valid pulses while holding the result
    out_ready = 1'b0;
    send(BLK_EMPTY, 1'b1, 1'b0, '0, 1'b1, H_EMPTY);
    n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 256'(out_valid), 256'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid    = i[0];
      block_data  = {16{$urandom_range(0, 32'hffff_ffff)}};
      first_block = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 256'(in_ready), 256'd1);
    chk("release_busy", 256'(busy), 256'd0);
    wait_drain();

    // Reset during ROUND, then chain with first_block=0 from the restored IV
    send(BLK_EMPTY, 1'b1, 1'b0, '0, 1'b0, '0);
    repeat (30) @(negedge clk);
    chk("abort_busy", 256'(busy), 256'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("abort");
    rst = 1'b0;
    send(BLK_ABC, 1'b0, 1'b0, '0, 1'b1, H_ABC);
    wait_drain();

`ifdef SHA256_MIDSTATE_IN_EN
    send(BLK_TWO2, 1'b1, 1'b1, H_MID, 1'b1, H_TWO);
    wait_drain();
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
